mem_req_frontend: RTL



---
 rtl/mem_req_frontend.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_req_frontend.sv
// Core request front-end: splits one request stream into write/read FIFOs, issues to the
// memory controller with outstanding-count limits and read-after-write hazard blocking.
module mem_req_frontend #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_address,
    input  logic [15:0] req_data,
    output logic        wr_en,
    output logic [15:0] wr_address,
    output logic [15:0] wr_data,
    input  logic        wr_ret_ack,
    input  logic [15:0] wr_ret_address,
    output logic        rd_en,
    output logic [15:0] rd_address,
    input  logic        rd_ret_ack,
    input  logic [15:0] rd_ret_address,
    input  logic [15:0] rd_ret_data,
    output logic        wr_resp_valid,
    output logic [15:0] wr_resp_address,
    output logic        rd_resp_valid,
    output logic [15:0] rd_resp_address,
    output logic [15:0] rd_resp_data,
    output logic        idle,
    output logic        err
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [15:0] wmem_addr [DEPTH];
    logic [15:0] wmem_data [DEPTH];
    logic [15:0] rmem_addr [DEPTH];
    logic [AW:0] w_wp, w_rp, r_wp, r_rp;
    logic [AW:0] w_count;
    logic [7:0]  wr_cnt, rd_cnt, wr_cnt_nxt, rd_cnt_nxt;
    logic        w_empty, w_full, r_empty, r_full;
    logic        w_push, r_push, w_pop, r_pop, conflict;
    logic [AW-1:0] idx;

    assign w_empty = (w_wp == w_rp);
    assign r_empty = (r_wp == r_rp);
    assign w_full  = (w_wp == {~w_rp[AW], w_rp[AW-1:0]});
    assign r_full  = (r_wp == {~r_rp[AW], r_rp[AW-1:0]});
    assign w_count = w_wp - w_rp;

    assign req_ready = req_we ? !w_full : !r_full;
    assign w_push    = req_valid && req_ready && req_we;
    assign r_push    = req_valid && req_ready && !req_we;
    assign idle      = w_empty && r_empty && (wr_cnt == 8'd0) && (rd_cnt == 8'd0);

    // Hazard check uses pre-pop state, so a write leaving the FIFO this cycle still blocks.
    always_comb begin
        conflict = 1'b0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = w_rp[AW-1:0] + AW'(i);
            if (((AW+1)'(i) < w_count) && (wmem_addr[idx] == rmem_addr[r_rp[AW-1:0]]))
                conflict = 1'b1;
        end
    end

    assign w_pop = !w_empty && (wr_cnt < MAX_CNT);
    assign r_pop = !r_empty && (rd_cnt < MAX_CNT) && (wr_cnt == 8'd0) && !conflict;

    always_comb begin
        wr_cnt_nxt = wr_cnt;
        if (w_pop && !wr_ret_ack)
            wr_cnt_nxt = wr_cnt + 8'd1;
        else if (!w_pop && wr_ret_ack && (wr_cnt != 8'd0))
            wr_cnt_nxt = wr_cnt - 8'd1;
    end

    always_comb begin
        rd_cnt_nxt = rd_cnt;
        if (r_pop && !rd_ret_ack)
            rd_cnt_nxt = rd_cnt + 8'd1;
        else if (!r_pop && rd_ret_ack && (rd_cnt != 8'd0))
            rd_cnt_nxt = rd_cnt - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            wmem_addr[w_wp[AW-1:0]] <= req_address;
            wmem_data[w_wp[AW-1:0]] <= req_data;
        end
        if (r_push)
            rmem_addr[r_wp[AW-1:0]] <= req_address;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_wp            <= '0;
            w_rp            <= '0;
            r_wp            <= '0;
            r_rp            <= '0;
            wr_cnt          <= 8'd0;
            rd_cnt          <= 8'd0;
            err             <= 1'b0;
            wr_en           <= 1'b0;
            wr_address      <= 16'd0;
            wr_data         <= 16'd0;
            rd_en           <= 1'b0;
            rd_address      <= 16'd0;
            wr_resp_valid   <= 1'b0;
            wr_resp_address <= 16'd0;
            rd_resp_valid   <= 1'b0;
            rd_resp_address <= 16'd0;
            rd_resp_data    <= 16'd0;
        end else begin
            if (w_push) w_wp <= w_wp + PTR_ONE;
            if (r_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop) begin
                w_rp       <= w_rp + PTR_ONE;
                wr_address <= wmem_addr[w_rp[AW-1:0]];
                wr_data    <= wmem_data[w_rp[AW-1:0]];
            end
            if (r_pop) begin
                r_rp       <= r_rp + PTR_ONE;
                rd_address <= rmem_addr[r_rp[AW-1:0]];
            end
            wr_en  <= w_pop;
            rd_en  <= r_pop;
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
            if ((wr_ret_ack && (wr_cnt == 8'd0)) || (rd_ret_ack && (rd_cnt == 8'd0)))
                err <= 1'b1;
            wr_resp_valid <= wr_ret_ack;
            rd_resp_valid <= rd_ret_ack;
            if (wr_ret_ack)
                wr_resp_address <= wr_ret_address;
            if (rd_ret_ack) begin
                rd_resp_address <= rd_ret_address;
                rd_resp_data    <= rd_ret_data;
            end
        end
    end
endmodule
